tristate_bus_arbiter: RTL and testbench
=======================================

# tristate_bus_arbiter

Round-robin arbiter and sequencer for a shared tri-state bus with N drivers, each gated by its own `'bz` enable. It guarantees at most one enable is active in any cycle. It inserts a fixed turnaround gap of all-released cycles between owners, so no two drivers ever overlap. It caps bus tenure so no requester can starve the others. The encoded owner output drives the select input of the downstream tri-state mux directly.

## Interface
- `N`, default 4: number of requesters/drivers, 2..16.
- `HOLD_MAX`, default 8: maximum consecutive cycles one owner may drive; 0 = unlimited.
- `TURNAROUND`, default 1: all-released cycles between two tenures, 1..15.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N: level request; bit i high = driver i wants the bus.
- `oe`, output, N: one-hot-or-zero drive enable; bit i high = driver i drives the bus this cycle.
- `sel`, output, $clog2(N): index of current or last owner; feeds the mux select.
- `busy`, output, 1: high iff any `oe` bit is high.
- `preempt`, output, 1: one-cycle pulse when a tenure ends by `HOLD_MAX` while the owner still requests.

## Operation
- States: IDLE, GRANT, TURN. All outputs are registered. The state, `oe`, `sel` and the counters update on the rising edge of `clk`.
- Reset (`rst_n` low, any time, asynchronous): state=IDLE, `oe`=0, `sel`=N-1, `busy`=0, `preempt`=0, hold and turn counters=0. Reset mid-tenure releases the bus immediately, without waiting for a clock edge.
- Round-robin winner: the first set bit of `req` searching from (`sel`+1) mod N upward, with wrap. After reset, requester 0 has top priority.
- IDLE, `req`≠0: go to GRANT. Set `oe`=onehot(winner), `sel`=winner, hold=1.
- IDLE, `req`=0: stay in IDLE. Outputs hold.
- GRANT, exit condition: `req[sel]`=0, or (`HOLD_MAX`≠0 and hold==`HOLD_MAX`).
  - On exit: go to TURN with `oe`=0, turn=1.
  - `preempt`=1 for that edge only if `req[sel]` is still 1.
- GRANT, otherwise: hold+=1, saturating. `oe` is unchanged.
- Requests from other drivers never shorten a tenure. Only release or `HOLD_MAX` ends it.
- TURN, turn<`TURNAROUND`: turn+=1. `oe` stays 0.
- TURN, turn==`TURNAROUND`, `req`≠0: go to GRANT with the round-robin winner. A preempted owner is searched last, so it wins again only if it is the sole requester.
- TURN, turn==`TURNAROUND`, `req`=0: go to IDLE.
- `sel` changes only on entry to GRANT. It holds its value through TURN and IDLE.
- Requests that drop during TURN or IDLE are simply not seen. Requests are never latched.
- `busy` equals the OR of `oe`, and is registered alongside `oe`.
- Invariants:
  - `oe` is never multi-hot.
  - `oe` never goes directly from one nonzero value to a different nonzero value.
  - Every pair of tenures is separated by at least `TURNAROUND` cycles with `oe`=0.

## Timing
- Grant latency from IDLE: `req` seen at edge k gives `oe` valid after edge k, i.e. 1 cycle.
- Release: `req[sel]` low at edge k gives `oe`=0 after edge k. The bus is released during the cycle following the owner's drop.
- Tenure length: 1..`HOLD_MAX` cycles while the owner holds `req`.
- Back-to-back handover gap: exactly `TURNAROUND` cycles of `oe`=0, then the next `oe` bit rises.
- Worst-case wait for a continuously requesting driver: (N-1)×(`HOLD_MAX`+`TURNAROUND`) + `TURNAROUND` + 1 cycles, with `HOLD_MAX`≠0.
- `preempt` is high for exactly one cycle, coincident with the first TURN cycle.

## Test plan
- Reset then single request: N=4, `req`=0100 held. `oe`=0100 and `sel`=2 one cycle later. Drop `req` → `oe`=0 next cycle; after 1 TURN cycle, state is IDLE.
- Simultaneous requests: `req`=1111 from IDLE after reset, each requester dropping after 3 cycles of ownership. Grant order is 0,1,2,3. Each tenure is 3 cycles, gaps are 1 cycle, and `oe` is never multi-hot.
- Preemption: `HOLD_MAX`=8, `req`=0011 held. Driver 0 gets 8 cycles, then `preempt`=1 for 1 cycle and 1 gap cycle, then driver 1 gets 8 cycles, then driver 0 again.
- Sole requester preempted: `req`=1000 held. Tenures of 8 cycles repeat with 1-cycle gaps; `sel` stays 3 and `preempt` pulses each time.
- Turnaround and wrap: `TURNAROUND`=3, `sel`=3 owner releases while `req`=0001. Exactly 3 cycles of `oe`=0, then `oe`=0001 and `sel`=0.
- Async reset mid-tenure: assert `rst_n`=0 between clock edges while `oe`=0010. `oe`=0, `busy`=0 and `sel`=3 take effect immediately. After release with `req`=1111, driver 0 is granted first.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter/sequencer for a shared tri-state bus: one-hot-or-zero enables,
// a fixed all-released turnaround gap between owners and an optional tenure cap.
module tristate_bus_arbiter #(
    parameter int N          = 4,
    parameter int HOLD_MAX   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         oe,
    output logic [$clog2(N)-1:0] sel,
    output logic                 busy,
    output logic                 preempt
);

    localparam int SW = $clog2(N);
    localparam int HW = $clog2(HOLD_MAX + 2);
    localparam int TW = 4;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          r_state, r_state_next;
    logic [N-1:0]    r_oe, r_oe_next;
    logic [SW-1:0]   r_sel, r_sel_next;
    logic            r_busy, r_busy_next;
    logic            r_preempt, r_preempt_next;
    logic [HW-1:0]   r_hold, r_hold_next;
    logic [TW-1:0]   r_turn, r_turn_next;

    logic [SW-1:0]   w_win;
    logic [N-1:0]    w_onehot;
    logic            w_any_req;
    logic            w_owner_req;
    logic            w_exit;

    // Search downward so the nearest requester after the current owner is written last;
    // the owner itself sits at distance N and therefore has the lowest priority.
    always_comb begin
        w_win = r_sel;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(r_sel) + k) % N]) begin
                w_win = SW'((int'(r_sel) + k) % N);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_win == SW'(gi));
        end
    endgenerate

    assign w_any_req   = |req;
    assign w_owner_req = req[r_sel];
    assign w_exit      = !w_owner_req || ((HOLD_MAX != 0) && (r_hold == HW'(HOLD_MAX)));

    always_comb begin
        r_state_next   = r_state;
        r_oe_next      = r_oe;
        r_sel_next     = r_sel;
        r_busy_next    = r_busy;
        r_preempt_next = 1'b0;
        r_hold_next    = r_hold;
        r_turn_next    = r_turn;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    r_state_next = GRANT;
                    r_oe_next    = w_onehot;
                    r_sel_next   = w_win;
                    r_busy_next  = 1'b1;
                    r_hold_next  = HW'(1);
                end
            end
            GRANT: begin
                if (w_exit) begin
                    r_state_next   = TURN;
                    r_oe_next      = '0;
                    r_busy_next    = 1'b0;
                    r_turn_next    = TW'(1);
                    r_preempt_next = w_owner_req;
                end else if (r_hold != '1) begin
                    r_hold_next = r_hold + HW'(1);
                end
            end
            TURN: begin
                if (r_turn < TW'(TURNAROUND)) begin
                    r_turn_next = r_turn + TW'(1);
                end else if (w_any_req) begin
                    r_state_next = GRANT;
                    r_oe_next    = w_onehot;
                    r_sel_next   = w_win;
                    r_busy_next  = 1'b1;
                    r_hold_next  = HW'(1);
                end else begin
                    r_state_next = IDLE;
                end
            end
            default: begin
                r_state_next = IDLE;
                r_oe_next    = '0;
                r_busy_next  = 1'b0;
            end
        endcase
    end

    // Asynchronous reset drops every enable at once so the bus is released mid-tenure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_oe      <= '0;
            r_sel     <= SW'(N - 1);
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_hold    <= '0;
            r_turn    <= '0;
        end else begin
            r_state   <= r_state_next;
            r_oe      <= r_oe_next;
            r_sel     <= r_sel_next;
            r_busy    <= r_busy_next;
            r_preempt <= r_preempt_next;
            r_hold    <= r_hold_next;
            r_turn    <= r_turn_next;
        end
    end

    assign oe      = r_oe;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench: DUT a uses defaults (N=4, HOLD_MAX=8, TURNAROUND=1); DUT b uses TURNAROUND=3.
module tb_tristate_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic [3:0] req_a = 4'b0000;
    logic [3:0] req_b = 4'b0000;
    logic [3:0] oe_a, oe_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b, pre_a, pre_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.N(4), .HOLD_MAX(8), .TURNAROUND(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .req(req_a),
        .oe(oe_a), .sel(sel_a), .busy(busy_a), .preempt(pre_a)
    );

    tristate_bus_arbiter #(.N(4), .HOLD_MAX(8), .TURNAROUND(3)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .req(req_b),
        .oe(oe_b), .sel(sel_b), .busy(busy_b), .preempt(pre_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_a();
        #2;
        rst_a_n = 1'b0;
        #1;
        rst_a_n = 1'b1;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_oe",   oe_a,   4'b0000);
        chk("rst_sel",  sel_a,  2'd3);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_pre",  pre_a,  1'b0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick();
        chk("idle_oe", oe_a, 4'b0000);

        // Single request, release, turnaround, idle
        req_a = 4'b0100;
        tick();
        chk("single_oe",   oe_a,   4'b0100);
        chk("single_sel",  sel_a,  2'd2);
        chk("single_busy", busy_a, 1'b1);
        req_a = 4'b0000;
        tick();
        chk("release_oe",   oe_a,   4'b0000);
        chk("release_busy", busy_a, 1'b0);
        chk("release_pre",  pre_a,  1'b0);
        tick();
        chk("idle_after_turn_oe",  oe_a,  4'b0000);
        chk("idle_after_turn_sel", sel_a, 2'd2);

        // Simultaneous requests: order 0,1,2,3, 3-cycle tenures, 1-cycle gaps
        reset_a();
        req_a = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                chk($sformatf("rr%0d_c%0d_oe", g, c), oe_a, 4'b0001 << g);
                chk($sformatf("rr%0d_c%0d_sel", g, c), sel_a, g);
            end
            req_a[g] = 1'b0;
            tick();
            chk($sformatf("rr%0d_gap_oe", g), oe_a, 4'b0000);
        end
        tick();
        chk("rr_end_idle_oe", oe_a, 4'b0000);

        // Preemption with two continuous requesters
        reset_a();
        req_a = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("pre0_c%0d_oe", c), oe_a, 4'b0001);
        end
        chk("pre0_tenure_pre", pre_a, 1'b0);
        tick();
        chk("pre0_turn_oe",  oe_a,  4'b0000);
        chk("pre0_turn_pre", pre_a, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("pre1_c%0d_oe", c), oe_a, 4'b0010);
        end
        chk("pre1_sel", sel_a, 2'd1);
        chk("pre1_pulse_gone", pre_a, 1'b0);
        tick();
        chk("pre1_turn_oe",  oe_a,  4'b0000);
        chk("pre1_turn_pre", pre_a, 1'b1);
        tick();
        chk("pre_back0_oe",  oe_a,  4'b0001);
        chk("pre_back0_sel", sel_a, 2'd0);

        // Sole requester preempted repeatedly
        req_a = 4'b1000;
        tick();
        chk("sole_handover_oe",  oe_a,  4'b0000);
        chk("sole_handover_pre", pre_a, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                chk($sformatf("sole%0d_c%0d_oe", r, c), oe_a, 4'b1000);
            end
            chk($sformatf("sole%0d_sel", r), sel_a, 2'd3);
            tick();
            chk($sformatf("sole%0d_gap_oe", r),  oe_a,  4'b0000);
            chk($sformatf("sole%0d_gap_pre", r), pre_a, 1'b1);
            chk($sformatf("sole%0d_gap_sel", r), sel_a, 2'd3);
        end
        tick();
        chk("sole_regrant_oe", oe_a, 4'b1000);

        // Async reset mid-tenure while driver 1 owns the bus
        req_a = 4'b0010;
        tick();
        chk("async_pre_gap_oe", oe_a, 4'b0000);
        tick();
        chk("async_owner_oe", oe_a, 4'b0010);
        #2;
        rst_a_n = 1'b0;
        #1;
        chk("async_oe",   oe_a,   4'b0000);
        chk("async_busy", busy_a, 1'b0);
        chk("async_sel",  sel_a,  2'd3);
        req_a = 4'b1111;
        #1;
        rst_a_n = 1'b1;
        tick();
        chk("async_first_oe",  oe_a,  4'b0001);
        chk("async_first_sel", sel_a, 2'd0);

        // Turnaround of 3 with wrap from owner 3 to requester 0
        req_b = 4'b1000;
        tick();
        chk("ta_owner_oe",  oe_b,  4'b1000);
        chk("ta_owner_sel", sel_b, 2'd3);
        req_b = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ta_gap%0d_oe", c), oe_b, 4'b0000);
        end
        chk("ta_gap_pre", pre_b, 1'b0);
        tick();
        chk("ta_wrap_oe",   oe_b,   4'b0001);
        chk("ta_wrap_sel",  sel_b,  2'd0);
        chk("ta_wrap_busy", busy_b, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
